rtc_clock: RTL
==============

Name: rtc_clock

Overview:
- BCD time-of-day counter (HH:MM:SS, 24 h) directly upstream of the RTC date stage.
- Divides the RTC reference clock into a 1 s tick and advances seconds, minutes and hours.
- Emits a one-cycle new_day pulse at midnight rollover, which feeds the date stage's new_day input.
- Provides a software-loadable time and a single programmable time-of-day alarm.

Parameters:
- CLK_DIV, 32768, reference-clock cycles per second; must be >= 2.
- CNT_W, $clog2(CLK_DIV), prescaler width; localparam, not overridable.

Ports:
- clk_i  in  1  RTC reference clock
- rstn_i  in  1  reset, synchronous, active-low
- enable_i  in  1  1 = time runs; 0 = prescaler and time frozen
- time_update_i  in  1  load time_i this cycle
- time_i  in  32  {10'b0, hh[5:0], 1'b0, mm[6:0], 1'b0, ss[6:0]}, BCD
- time_o  out  32  current time, same packing as time_i, unused bits 0
- alarm_update_i  in  1  load alarm_i into the alarm register
- alarm_i  in  32  alarm time, same packing
- alarm_en_i  in  1  alarm compare enable
- alarm_event_o  out  1  one-cycle alarm pulse
- sec_tick_o  out  1  one-cycle pulse when seconds advance
- new_day_o  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover

Behaviour:
- All state is sampled on the clk_i rising edge. Reset takes effect only when rstn_i = 0 at an edge.
- Reset values:
  - prescaler = 0
  - time = 00:00:00, so time_o = 0
  - alarm register = 0
  - sec_tick_o, new_day_o, alarm_event_o = 0
- Prescaler:
  - When enable_i = 1, it counts 0..CLK_DIV-1.
  - An internal tick occurs on the edge where prescaler == CLK_DIV-1 and enable_i = 1; the prescaler then wraps to 0.
  - When enable_i = 0, the prescaler holds and no tick occurs.
- Time advance on a tick:
  - Seconds units increment. On 9 they go to 0 and carry into seconds tens.
  - Seconds 0x59 -> 0x00, with a carry into minutes. Minutes follow the same rule.
  - Hours: units increment with carry at 9; 0x23 -> 0x00.
  - Only fields that change are written.
- Registered pulses:
  - sec_tick_o goes high in the cycle after the tick edge, i.e. the first cycle time_o shows the new value.
  - new_day_o goes high in that same cycle, only when the tick produced 00:00:00 from 23:59:59. So new_day_o = 1 exactly while time_o first reads 0.
- Invalid BCD:
  - Software must load valid BCD; no checking or saturation is performed.
  - A units digit of A–F increments modulo 16 without carry. The field recovers within 16 ticks.
  - Tens and hours wrap only on the exact values 0x59 / 0x23.
- time_update_i:
  - Loads the time, clears the prescaler to 0 and suppresses any tick in that cycle. No sec_tick_o, new_day_o or alarm pulse results.
  - The first tick after a load comes exactly CLK_DIV enabled cycles later.
- alarm_update_i:
  - Loads the alarm register. It is independent of time_update_i, and both may load in the same cycle.
- Alarm:
  - alarm_event_o = 1 in the cycle after a tick edge when alarm_en_i = 1 and the new time equals the alarm register.
  - Only ss/mm/hh bits are compared.
  - Loading a time equal to the alarm does not fire.
  - Changing the alarm or alarm_en_i never fires by itself.
- Simultaneous events:
  - time_update_i has priority over a tick.
  - An alarm load in the tick cycle is compared against the old alarm value.
- enable_i falling mid-second: the prescaler value is retained and counting resumes from it.
- Latency: time_i -> time_o is 1 cycle. Tick edge -> time_o, sec_tick_o, new_day_o, alarm_event_o is 1 cycle.

Decomposition:
- Package rtc_pkg holds:
  - field offsets and widths for ss/mm/hh in the 32-bit word;
  - BCD constants 0x59 and 0x23;
  - a packed struct rtc_time_t {hh, mm, ss};
  - pack/unpack functions shared with the date stage's register interface.
- One sub-module, rtc_bcd_field:
  - a two-digit BCD counter with parameter MAX_BCD (0x59 or 0x23);
  - inputs: load, load value, inc;
  - outputs: value, wrap (combinational: inc && value == MAX_BCD).
  - Instantiated three times (ss, mm, hh), chained via wrap.

Test Plan:
- Reset, then CLK_DIV = 4 and enable_i = 1 for 12 cycles -> time_o = 0x00000003; sec_tick_o pulses every 4th cycle, one cycle wide.
- Load 0x00235958, run 2 ticks:
  - after tick 1, time_o = 0x00235959;
  - after tick 2, time_o = 0x00000000 and new_day_o = 1 for exactly that cycle.
- Load 0x00095959, one tick -> time_o = 0x00100000; new_day_o stays 0.
- Alarm 0x00120001 with alarm_en_i = 1, time loaded 0x00120000:
  - one tick -> alarm_event_o = 1 for 1 cycle;
  - repeat with alarm_en_i = 0 -> no pulse;
  - loading time 0x00120001 directly -> no pulse.
- time_update_i asserted in the tick cycle with 0x00010203 -> time_o = 0x00010203, no sec_tick_o; the next tick arrives CLK_DIV cycles later.
- enable_i dropped for 10 cycles mid-second, then a synchronous reset asserted mid-count -> time frozen while disabled; the prescaler resumes; after the reset edge all outputs are 0.

Source files
------------

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared time-word layout, BCD limits and pack/unpack helpers for the RTC stages
package rtc_pkg;
  localparam int SS_LSB = 0;
  localparam int SS_W   = 7;
  localparam int MM_LSB = 8;
  localparam int MM_W   = 7;
  localparam int HH_LSB = 16;
  localparam int HH_W   = 6;
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;
  typedef struct packed {
    logic [HH_W-1:0] hh;
    logic [MM_W-1:0] mm;
    logic [SS_W-1:0] ss;
  } rtc_time_t;
  function automatic rtc_time_t rtc_unpack(logic [31:0] w);
    rtc_time_t t;
    t.hh = w[HH_LSB +: HH_W];
    t.mm = w[MM_LSB +: MM_W];
    t.ss = w[SS_LSB +: SS_W];
    return t;
  endfunction
  function automatic logic [31:0] rtc_pack(rtc_time_t t);
    return {10'b0, t.hh, 1'b0, t.mm, 1'b0, t.ss};
  endfunction
  // Units A-F step modulo 16 without carry so a bad load recovers on its own
  function automatic logic [7:0] bcd_inc(logic [7:0] v, logic [7:0] max);
    return v == max ? 8'h00 :
           v[3:0] == 4'h9 ? {v[7:4] + 4'h1, 4'h0} : {v[7:4], v[3:0] + 4'h1};
  endfunction
endpackage

// File: rtl/rtc_bcd_field.sv
// rtc_bcd_field: two-digit BCD counter wrapping to 0 after MAX_BCD
module rtc_bcd_field
  import rtc_pkg::*;
#(
  parameter int         W       = 7,
  parameter logic [7:0] MAX_BCD = BCD_59
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         wrap
);
  assign wrap = inc && value == MAX_BCD[W-1:0];
  always_ff @(posedge clk_i) begin
    if (!rstn_i) value <= '0;
    else if (load) value <= load_val;
    else if (inc) value <= W'(bcd_inc(8'(value), MAX_BCD));
  end
endmodule

// File: rtl/rtc_clock.sv
// rtc_clock: 24 h BCD time-of-day counter with 1 s prescaler, load and single alarm
module rtc_clock
  import rtc_pkg::*;
#(
  parameter int CLK_DIV = 32768
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        enable_i,
  input  logic        time_update_i,
  input  logic [31:0] time_i,
  output logic [31:0] time_o,
  input  logic        alarm_update_i,
  input  logic [31:0] alarm_i,
  input  logic        alarm_en_i,
  output logic        alarm_event_o,
  output logic        sec_tick_o,
  output logic        new_day_o
);
  localparam int CNT_W = $clog2(CLK_DIV);
  logic [CNT_W-1:0] cnt;
  logic tick, ss_wrap, mm_wrap, hh_wrap;
  rtc_time_t ld, cur, nxt, alarm_q;
  assign ld   = rtc_unpack(time_i);
  assign tick = enable_i && !time_update_i && cnt == CNT_W'(CLK_DIV - 1);
  rtc_bcd_field #(.W(SS_W), .MAX_BCD(BCD_59)) u_ss (
    .clk_i, .rstn_i, .load(time_update_i), .load_val(ld.ss), .inc(tick),
    .value(cur.ss), .wrap(ss_wrap)
  );
  rtc_bcd_field #(.W(MM_W), .MAX_BCD(BCD_59)) u_mm (
    .clk_i, .rstn_i, .load(time_update_i), .load_val(ld.mm), .inc(ss_wrap),
    .value(cur.mm), .wrap(mm_wrap)
  );
  rtc_bcd_field #(.W(HH_W), .MAX_BCD(BCD_23)) u_hh (
    .clk_i, .rstn_i, .load(time_update_i), .load_val(ld.hh), .inc(mm_wrap),
    .value(cur.hh), .wrap(hh_wrap)
  );
  assign time_o = rtc_pack(cur);
  // Time the counters will hold after this edge if it is a tick, for the alarm compare
  assign nxt.ss = SS_W'(bcd_inc(8'(cur.ss), BCD_59));
  assign nxt.mm = ss_wrap ? MM_W'(bcd_inc(8'(cur.mm), BCD_59)) : cur.mm;
  assign nxt.hh = mm_wrap ? HH_W'(bcd_inc(8'(cur.hh), BCD_23)) : cur.hh;
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt           <= '0;
      alarm_q       <= '0;
      sec_tick_o    <= 1'b0;
      new_day_o     <= 1'b0;
      alarm_event_o <= 1'b0;
    end else begin
      cnt           <= (time_update_i || tick) ? '0 : enable_i ? cnt + CNT_W'(1) : cnt;
      if (alarm_update_i) alarm_q <= rtc_unpack(alarm_i);
      sec_tick_o    <= tick;
      new_day_o     <= hh_wrap;
      alarm_event_o <= tick && alarm_en_i && nxt == alarm_q;
    end
  end
endmodule
